// File: rtl/sym_delay_line.sv
`default_nettype none
// ============================================================================
//  Module      : sym_delay_line
//  Description : Tapped delay line for symmetric FIR filters. Holds DEPTH
//                signed samples (stage 0 = newest), reports fill level and
//                optionally pre-adds mirrored stage pairs (i, DEPTH-1-i) into
//                DATA_W+1 bit registered sums with a one-cycle valid strobe.
//  Config      : define SYM_PREADD_EN to build the pre-adder and pair_sum
//                registers; when undefined pair_sum is tied to zero while
//                sum_valid keeps identical timing.
//  Revision    : 1.0 - initial release
// ============================================================================
module sym_delay_line #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 8
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                en,
  input  logic                                flush,
  input  logic [DATA_W-1:0]                   sin,
  output logic [DEPTH*DATA_W-1:0]             taps,
  output logic [(DEPTH/2)*(DATA_W+1)-1:0]     pair_sum,
  output logic                                sum_valid,
  output logic [$clog2(DEPTH+1)-1:0]          fill_cnt,
  output logic                                primed
);

  localparam int c_cnt_w = $clog2(DEPTH + 1);
  localparam int c_pairs = DEPTH / 2;
  localparam int c_sum_w = DATA_W + 1;
  localparam logic [c_cnt_w-1:0] c_fill_max = c_cnt_w'(DEPTH);

  // --------------------------------------------------------------------------
  // Parameter legality: refuse to elaborate an odd, too-short or badly sized
  // line rather than silently building a half-paired pre-adder.
  // --------------------------------------------------------------------------
  if ((DEPTH < 2) || ((DEPTH % 2) != 0)) begin : g_bad_depth
    $error("sym_delay_line: DEPTH must be even and at least 2");
  end

  if ((DATA_W < 2) || (DATA_W > 32)) begin : g_bad_width
    $error("sym_delay_line: DATA_W must lie in 2..32");
  end

  // --------------------------------------------------------------------------
  // Shared control: a shift is accepted only when flush does not override it.
  // --------------------------------------------------------------------------
  logic shift_accept;
  assign shift_accept = en & ~flush;

  // --------------------------------------------------------------------------
  // Delay-line storage
  // --------------------------------------------------------------------------
  logic [DATA_W-1:0] stage_q [DEPTH];
  logic [DATA_W-1:0] stage_d [DEPTH];

  // Next-state of the stages: clear on flush, shift on accepted enable, else hold.
  always_comb begin
    for (int k = 0; k < DEPTH; k++) begin
      stage_d[k] = stage_q[k];
    end
    if (flush) begin
      for (int k = 0; k < DEPTH; k++) begin
        stage_d[k] = '0;
      end
    end else if (en) begin
      stage_d[0] = sin;
      for (int k = 1; k < DEPTH; k++) begin
        stage_d[k] = stage_q[k-1];
      end
    end
  end

  // Stage registers; reset clears history so unfilled stages read zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < DEPTH; k++) begin
        stage_q[k] <= '0;
      end
    end else begin
      for (int k = 0; k < DEPTH; k++) begin
        stage_q[k] <= stage_d[k];
      end
    end
  end

  // Taps come straight off the stage registers, no extra pipeline.
  for (genvar k = 0; k < DEPTH; k++) begin : g_taps
    assign taps[k*DATA_W +: DATA_W] = stage_q[k];
  end

  // --------------------------------------------------------------------------
  // Fill level
  // --------------------------------------------------------------------------
  logic [c_cnt_w-1:0] fill_cnt_q;
  logic [c_cnt_w-1:0] fill_cnt_d;

  // Count accepted shifts, saturating once the line is full.
  always_comb begin
    fill_cnt_d = fill_cnt_q;
    if (flush) begin
      fill_cnt_d = '0;
    end else if (en && (fill_cnt_q != c_fill_max)) begin
      fill_cnt_d = fill_cnt_q + c_cnt_w'(1);
    end
  end

  // Fill counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fill_cnt_q <= '0;
    end else begin
      fill_cnt_q <= fill_cnt_d;
    end
  end

  assign fill_cnt = fill_cnt_q;
  assign primed   = (fill_cnt_q == c_fill_max);

  // --------------------------------------------------------------------------
  // Valid strobe pipeline. sum_pend marks "the shift just taken left the line
  // full"; one edge later the sums are captured and sum_valid goes high for
  // the cycle that follows. This path exists in both builds so downstream
  // control sees the same strobe whether or not the adders are present.
  // --------------------------------------------------------------------------
  logic sum_pend_q;
  logic sum_pend_d;
  logic sum_valid_q;
  logic sum_valid_d;

  // Pending flag and strobe; flush kills both so no pulse escapes a clear.
  always_comb begin
    sum_pend_d  = shift_accept && (fill_cnt_d == c_fill_max);
    sum_valid_d = flush ? 1'b0 : sum_pend_q;
  end

  // Strobe pipeline registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_pend_q  <= 1'b0;
      sum_valid_q <= 1'b0;
    end else begin
      sum_pend_q  <= sum_pend_d;
      sum_valid_q <= sum_valid_d;
    end
  end

  assign sum_valid = sum_valid_q;

`ifdef SYM_PREADD_EN
  // --------------------------------------------------------------------------
  // Symmetric pre-adder. Sums are taken from the stages one edge after an
  // accepted shift, including shifts made before priming (unfilled stages
  // are zero, so those sums are well defined, just not flagged).
  // --------------------------------------------------------------------------
  logic               shift_pend_q;
  logic               shift_pend_d;
  logic [c_sum_w-1:0] pair_sum_q [c_pairs];
  logic [c_sum_w-1:0] pair_sum_d [c_pairs];

  // Remember that the previous edge shifted, so the sums refresh next edge.
  always_comb begin
    shift_pend_d = shift_accept;
  end

  // Sign-extended mirrored-pair addition; one extra bit so the sum never wraps.
  always_comb begin
    for (int i = 0; i < c_pairs; i++) begin
      pair_sum_d[i] = pair_sum_q[i];
    end
    if (flush) begin
      for (int i = 0; i < c_pairs; i++) begin
        pair_sum_d[i] = '0;
      end
    end else if (shift_pend_q) begin
      for (int i = 0; i < c_pairs; i++) begin
        pair_sum_d[i] = {stage_q[i][DATA_W-1], stage_q[i]}
                      + {stage_q[DEPTH-1-i][DATA_W-1], stage_q[DEPTH-1-i]};
      end
    end
  end

  // Pre-adder result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_pend_q <= 1'b0;
      for (int i = 0; i < c_pairs; i++) begin
        pair_sum_q[i] <= '0;
      end
    end else begin
      shift_pend_q <= shift_pend_d;
      for (int i = 0; i < c_pairs; i++) begin
        pair_sum_q[i] <= pair_sum_d[i];
      end
    end
  end

  for (genvar i = 0; i < c_pairs; i++) begin : g_pair_out
    assign pair_sum[i*c_sum_w +: c_sum_w] = pair_sum_q[i];
  end
`else
  // Pre-adder not built: the sum bus is constant zero.
  assign pair_sum = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_sym_delay_line.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sym_delay_line
//  Description : Self-checking bench for sym_delay_line. A queue-based
//                reference model (newest sample at the front) predicts taps,
//                fill level, pair sums and the valid strobe. Follows the
//                SYM_PREADD_EN setting of the build for pair_sum.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sym_delay_line;

  localparam int W  = 16;
  localparam int D  = 8;
  localparam int CW = $clog2(D + 1);
  localparam int PW = W + 1;

  logic                    clk = 1'b0;
  logic                    rst_n = 1'b0;
  logic                    en = 1'b0;
  logic                    flush = 1'b0;
  logic [W-1:0]            sin = '0;
  logic [D*W-1:0]          taps;
  logic [(D/2)*PW-1:0]     pair_sum;
  logic                    sum_valid;
  logic [CW-1:0]           fill_cnt;
  logic                    primed;

  int checks = 0;
  int errors = 0;

  sym_delay_line #(
    .DATA_W (W),
    .DEPTH  (D)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .flush     (flush),
    .sin       (sin),
    .taps      (taps),
    .pair_sum  (pair_sum),
    .sum_valid (sum_valid),
    .fill_cnt  (fill_cnt),
    .primed    (primed)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  logic [W-1:0]  hist [$];        // accepted samples, newest first, at most D
  logic [PW-1:0] m_ps [D/2];      // most recently captured pair sums
  bit            m_sv;            // expected strobe this cycle
  bit            m_pend_shift;    // previous edge accepted a sample
  bit            m_pend_valid;    // ...and that sample filled the line

  function automatic logic [W-1:0] m_tap(input int k);
    if (k < hist.size()) return hist[k];
    return '0;
  endfunction

  task automatic model_reset();
    hist.delete();
    for (int i = 0; i < D/2; i++) m_ps[i] = '0;
    m_sv = 1'b0;
    m_pend_shift = 1'b0;
    m_pend_valid = 1'b0;
  endtask

  task automatic model_edge(input logic e, input logic f, input logic [W-1:0] s);
    int a;
    int b;
    if (f) begin
      model_reset();
    end else begin
      if (m_pend_shift) begin
        for (int i = 0; i < D/2; i++) begin
          a = $signed(m_tap(i));
          b = $signed(m_tap(D-1-i));
          m_ps[i] = PW'(a + b);
        end
      end
      m_sv = m_pend_shift && m_pend_valid;
      if (e) begin
        hist.push_front(s);
        if (hist.size() > D) void'(hist.pop_back());
        m_pend_shift = 1'b1;
        m_pend_valid = (hist.size() == D);
      end else begin
        m_pend_shift = 1'b0;
        m_pend_valid = 1'b0;
      end
    end
  endtask

  task automatic check_all(input string tag);
    logic [D*W-1:0]      exp_taps;
    logic [(D/2)*PW-1:0] exp_ps;
    logic [CW-1:0]       exp_fill;
    logic                exp_primed;
    for (int k = 0; k < D; k++) exp_taps[k*W +: W] = m_tap(k);
    exp_ps = '0;
`ifdef SYM_PREADD_EN
    for (int i = 0; i < D/2; i++) exp_ps[i*PW +: PW] = m_ps[i];
`endif
    exp_fill   = CW'(hist.size());
    exp_primed = (hist.size() == D);

    checks++;
    assert (taps === exp_taps) else begin
      errors++;
      $error("FAIL %s taps: got %h expected %h", tag, taps, exp_taps);
    end
    checks++;
    assert (fill_cnt === exp_fill) else begin
      errors++;
      $error("FAIL %s fill_cnt: got %0d expected %0d", tag, fill_cnt, exp_fill);
    end
    checks++;
    assert (primed === exp_primed) else begin
      errors++;
      $error("FAIL %s primed: got %b expected %b", tag, primed, exp_primed);
    end
    checks++;
    assert (pair_sum === exp_ps) else begin
      errors++;
      $error("FAIL %s pair_sum: got %h expected %h", tag, pair_sum, exp_ps);
    end
    checks++;
    assert (sum_valid === m_sv) else begin
      errors++;
      $error("FAIL %s sum_valid: got %b expected %b", tag, sum_valid, m_sv);
    end
  endtask

  // Drive one cycle of inputs, let the edge happen, then check 1 ns later.
  task automatic step(input logic e, input logic f, input logic [W-1:0] s, input string tag);
    en = e;
    flush = f;
    sin = s;
    @(posedge clk);
    model_edge(e, f, s);
    #1;
    check_all(tag);
  endtask

  int pulses;
  logic [PW-1:0] exp_pair;

  initial begin
    model_reset();

    // Reset state while rst_n is low and the clock runs
    #12;
    check_all("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Samples 1..8, then an idle cycle to observe the strobe and sums
    for (int k = 1; k <= D; k++) step(1'b1, 1'b0, W'(k), "ramp");
    checks++;
    assert (primed === 1'b1 && taps[W-1:0] === 16'd8 && taps[(D-1)*W +: W] === 16'd1) else begin
      errors++;
      $error("FAIL ramp_primed: primed %b tap0 %0d tap7 %0d expected 1/8/1",
             primed, taps[W-1:0], taps[(D-1)*W +: W]);
    end
    step(1'b0, 1'b0, '0, "ramp_idle");
`ifdef SYM_PREADD_EN
    exp_pair = 17'd9;
`else
    exp_pair = '0;
`endif
    checks++;
    assert (sum_valid === 1'b1 && pair_sum[PW-1:0] === exp_pair && pair_sum[3*PW +: PW] === exp_pair) else begin
      errors++;
      $error("FAIL ramp_sum: sum_valid %b pair0 %h pair3 %h expected 1/%h", sum_valid,
             pair_sum[PW-1:0], pair_sum[3*PW +: PW], exp_pair);
    end
    step(1'b0, 1'b0, '0, "ramp_idle2");

    // Signed extremes
    for (int k = 0; k < D; k++) step(1'b1, 1'b0, 16'h7FFF, "max");
    step(1'b0, 1'b0, '0, "max_idle");
`ifdef SYM_PREADD_EN
    exp_pair = 17'h0FFFE;
`else
    exp_pair = '0;
`endif
    checks++;
    assert (pair_sum[PW-1:0] === exp_pair) else begin
      errors++;
      $error("FAIL max_sum: got %h expected %h", pair_sum[PW-1:0], exp_pair);
    end
    for (int k = 0; k < D; k++) step(1'b1, 1'b0, 16'h8000, "min");
    step(1'b0, 1'b0, '0, "min_idle");
`ifdef SYM_PREADD_EN
    exp_pair = 17'h10000;
`else
    exp_pair = '0;
`endif
    checks++;
    assert (pair_sum[PW-1:0] === exp_pair) else begin
      errors++;
      $error("FAIL min_sum: got %h expected %h", pair_sum[PW-1:0], exp_pair);
    end

    // en toggled 1,0,1 on a primed line: two strobes expected
    pulses = 0;
    step(1'b1, 1'b0, 16'h0123, "tog1");
    if (sum_valid) pulses++;
    step(1'b0, 1'b0, 16'h0456, "tog0");
    if (sum_valid) pulses++;
    step(1'b1, 1'b0, 16'h0789, "tog1b");
    if (sum_valid) pulses++;
    step(1'b0, 1'b0, '0, "tog_idle");
    if (sum_valid) pulses++;
    step(1'b0, 1'b0, '0, "tog_idle2");
    if (sum_valid) pulses++;
    checks++;
    assert (pulses == 2) else begin
      errors++;
      $error("FAIL toggle_pulses: got %0d expected 2", pulses);
    end

    // Flush with simultaneous en on a primed line
    step(1'b1, 1'b1, 16'd5, "flush");
    step(1'b0, 1'b0, '0, "flush_after");

    // Asynchronous reset mid-cycle after 5 samples
    for (int k = 0; k < 5; k++) step(1'b1, 1'b0, W'($urandom), "pre_rst");
    en = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all("async_rst");
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < D; k++) step(1'b1, 1'b0, W'($urandom), "refill");
    step(1'b1, 1'b0, W'($urandom), "refill_more");

    // Randomized traffic
    for (int n = 0; n < 400; n++) begin
      step(($urandom_range(0, 3) != 0), ($urandom_range(0, 24) == 0),
           W'($urandom), "random");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/sym_delay_line.md
SYM_DELAY_LINE -- requirements
Module: sym_delay_line

Interface
REQ-001 SHALL have parameter DATA_W, default 16: sample width in bits, signed two's complement, range 2..32.
REQ-002 SHALL have parameter DEPTH, default 8: number of delay stages; DEPTH SHALL be even and at least 2, and elaboration SHALL fail otherwise.
REQ-003 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port en, input, 1 bit: shift enable; a new sample is accepted on every cycle it is high.
REQ-006 SHALL have port flush, input, 1 bit: synchronous clear of the line.
REQ-007 SHALL have port sin, input, DATA_W bits: input sample.
REQ-008 SHALL have port taps, output, DEPTH*DATA_W bits: stage k is taps[k*DATA_W +: DATA_W], and stage 0 is the newest sample.
REQ-009 SHALL have port pair_sum, output, (DEPTH/2)*(DATA_W+1) bits: symmetric pre-add results, with pair i at slice i*(DATA_W+1).
REQ-010 SHALL have port sum_valid, output, 1 bit: single-cycle strobe marking a pair_sum update computed from a fully primed line.
REQ-011 SHALL have port fill_cnt, output, $clog2(DEPTH+1) bits: number of valid samples held.
REQ-012 SHALL have port primed, output, 1 bit: high when fill_cnt equals DEPTH.

Function
REQ-013 On an edge with en=1 and flush=0, the line SHALL shift: stage 0 <= sin and stage k <= stage k-1 for k = 1..DEPTH-1.
REQ-014 When en=0 and flush=0, all stages, fill_cnt and pair_sum SHALL hold their values.
REQ-015 flush=1 SHALL clear all stages, fill_cnt, pair_sum and sum_valid on the next edge, regardless of en; a simultaneous en sample is discarded.
REQ-016 fill_cnt SHALL increment on each accepted shift and saturate at DEPTH; it SHALL never wrap.
REQ-017 primed SHALL be combinational from fill_cnt (fill_cnt == DEPTH), with no added latency.
REQ-018 The taps output SHALL be driven directly from the stage registers, with zero latency after the shifting edge.
REQ-019 pair_sum[i] SHALL be registered as sign-extended stage i plus sign-extended stage DEPTH-1-i, for i = 0..DEPTH/2-1, using DATA_W+1 bits so the sum cannot overflow.
REQ-020 pair_sum SHALL update on the edge following an accepted shift, so its latency from the sample edge is 1 cycle; it SHALL hold otherwise.
REQ-021 sum_valid SHALL be high for exactly one cycle, the cycle after the edge on which pair_sum updated, if and only if fill_cnt was DEPTH after the shift that produced that update.
REQ-022 With en held high continuously and the line primed, sum_valid SHALL be high every cycle.
REQ-023 On the shift that brings fill_cnt from DEPTH-1 to DEPTH, sum_valid SHALL assert 1 cycle later.
REQ-024 Partially filled stages SHALL read zero, so pair_sum values before priming are defined but not flagged valid.

Reset
REQ-025 While rst_n=0, all stages, pair_sum, fill_cnt and sum_valid SHALL be 0 immediately, independent of clk.
REQ-026 Consequently primed SHALL be 0 during reset.
REQ-027 Reset asserted mid-stream SHALL discard all history; after release, priming SHALL restart from fill_cnt=0.
REQ-028 The first edge after rst_n rises with en=1 SHALL shift normally.

Configuration
REQ-029 Macro SYM_PREADD_EN SHALL control the pre-adder.
REQ-030 With SYM_PREADD_EN defined, the pre-adder, pair_sum registers and sum_valid SHALL operate per REQ-019 to REQ-024.
REQ-031 With SYM_PREADD_EN undefined, no adders or pair_sum registers SHALL be built: pair_sum SHALL be tied to 0, and sum_valid SHALL follow the same timing as when defined (strobe 1 cycle after each primed shift), so downstream control is unchanged.

Verification
REQ-032 DATA_W=16, DEPTH=8: shift in samples 1..8 with en=1 -> taps = {8,7,...,1} with stage 0 = 8; primed rises on the 8th edge; sum_valid pulses once, 1 cycle later, with every pair_sum = 9.
REQ-033 Signed extremes: shift 0x7FFF into all stages -> pair_sum = 0x0FFFE (17 bits); repeat with 0x8000 -> pair_sum = 0x10000.
REQ-034 Primed line, en toggled 1,0,1 -> taps and pair_sum hold during the en=0 cycle, and sum_valid follows each accepted shift by 1 cycle, giving 2 pulses.
REQ-035 Primed line, flush=1 together with en=1 and sin=5 -> next cycle all taps = 0, fill_cnt = 0, primed = 0, and no sum_valid pulse.
REQ-036 Assert rst_n=0 asynchronously mid-cycle after 5 samples -> outputs clear before the next edge; after release, 8 more samples are needed before primed rises.
REQ-037 Rebuild with SYM_PREADD_EN undefined and rerun REQ-032 -> pair_sum = 0 throughout, with identical sum_valid timing.
